// File: rtl/dmem_req_master_if.sv
// Data-memory bus between the MEM-stage initiator (master) and the memory/cache responder (slave).
// Address phase: bus_req_o is the valid and bus_addr_ok_i the ready; both high on a clock edge transfers the request.
// Data phase: bus_data_ok_i is a one-cycle strobe, carrying read data or a write acknowledge.
// The master keeps addr/be/wdata/wr unchanged from bus_req_o rising until the transfer edge.
interface dmem_req_master_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req_o;
    logic              bus_wr_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_be_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_addr_ok_i;
    logic              bus_data_ok_i;
    logic [31:0]       bus_rdata_i;

    modport master (
        output bus_req_o, bus_wr_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_wr_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );
endinterface

// File: rtl/dmem_req_master.sv
// MEM-stage data-memory initiator: one load/store becomes one word-aligned bus access with byte
// enables; load data comes back lane-extracted and extended, with a timeout abort in the data phase.
module dmem_req_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_wr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_sign_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              addr_err_o,
    output logic              bus_err_o,
    output logic [1:0]        dbg_state_o,
    dmem_req_master_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, sign_q, err_q;
    logic [1:0]        size_q, lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              misaligned;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [15:0]       half_w;
    logic [7:0]        byte_w;
    logic [31:0]       load_ext;
    logic              accept, capture, err_set, cnt_clr, cnt_inc, in_req;

    // Byte accesses are always aligned; size 2'b11 behaves as a word.
    always_comb begin
        misaligned = |req_addr_i[1:0];
        case (req_size_i)
            2'b01:   misaligned = req_addr_i[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = |req_addr_i[1:0];
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata_i;
        case (req_size_i)
            2'b01: begin
                be_calc    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {req_wdata_i[15:0], req_wdata_i[15:0]};
            end
            2'b10: begin
                be_calc    = 4'b0001 << req_addr_i[1:0];
                wdata_calc = {4{req_wdata_i[7:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata_i;
            end
        endcase
    end

    always_comb begin
        half_w   = lo_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
        byte_w   = bus.bus_rdata_i[7:0];
        load_ext = bus.bus_rdata_i;
        case (lo_q)
            2'd1:    byte_w = bus.bus_rdata_i[15:8];
            2'd2:    byte_w = bus.bus_rdata_i[23:16];
            2'd3:    byte_w = bus.bus_rdata_i[31:24];
            default: byte_w = bus.bus_rdata_i[7:0];
        endcase
        case (size_q)
            2'b01:   load_ext = sign_q ? {{16{half_w[15]}}, half_w} : {16'h0, half_w};
            2'b10:   load_ext = sign_q ? {{24{byte_w[7]}}, byte_w} : {24'h0, byte_w};
            default: load_ext = bus.bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        addr_err_o = 1'b0;
        done_o     = 1'b0;
        in_req     = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        err_set    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst so the reset-state outputs read zero even with a request pending.
                if (req_valid_i && !rst) begin
                    if (misaligned) begin
                        addr_err_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        accept  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                in_req  = 1'b1;
                if (bus.bus_addr_ok_i) begin
                    if (bus.bus_data_ok_i) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                stall_o = 1'b1;
                if (bus.bus_data_ok_i) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            lo_q    <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= req_wr_i;
                sign_q  <= req_sign_i;
                size_q  <= req_size_i;
                lo_q    <= req_addr_i[1:0];
                addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                be_q    <= req_wr_i ? be_calc : 4'b0000;
                wdata_q <= req_wr_i ? wdata_calc : 32'h0;
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                rdata_q <= wr_q ? 32'h0 : load_ext;
            end
            if (err_set) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
        end
    end

    // Bus qualifiers are driven only in the address phase so the bus idles at zero.
    assign bus.bus_req_o   = in_req;
    assign bus.bus_wr_o    = in_req & wr_q;
    assign bus.bus_addr_o  = in_req ? addr_q : '0;
    assign bus.bus_be_o    = in_req ? be_q : 4'b0000;
    assign bus.bus_wdata_o = in_req ? wdata_q : 32'h0;

    assign rdata_o     = done_o ? rdata_q : 32'h0;
    assign bus_err_o   = done_o & err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_req_master.sv
// Self-checking bench for dmem_req_master: directed scenarios plus randomized load/store traffic,
// checked cycle by cycle against a transaction-level expectation queue.
module tb_dmem_req_master;

    localparam int TO = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_wr, req_sign;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          stall, done, addr_err, bus_err;
    logic [31:0]   rdata;
    logic [1:0]    dbg_state;

    dmem_req_master_if #(.ADDR_W(AW)) bus_if ();

    dmem_req_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_wr_i    (req_wr),
        .req_size_i  (req_size),
        .req_sign_i  (req_sign),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .stall_o     (stall),
        .done_o      (done),
        .rdata_o     (rdata),
        .addr_err_o  (addr_err),
        .bus_err_o   (bus_err),
        .dbg_state_o (dbg_state),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        idle;
        logic        stall;
        logic        done;
        logic        addr_err;
        logic        bus_err;
        logic        bus_req;
        logic        bus_wr;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    localparam int EW = $bits(exp_t);
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b10) return 1'b0;
        if (size == 2'b01) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        int base;
        if (!wr) return 4'b0000;
        if (size == 2'b10) return 4'(1 << addr[1:0]);
        if (size == 2'b01) begin
            base = addr[1] ? 2 : 0;
            return 4'(3 << base);
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic wr, input logic [1:0] size, input logic [31:0] d);
        if (!wr) return 32'h0;
        if (size == 2'b10) return (d & 32'hFF) * 32'h01010101;
        if (size == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_rdata(input logic wr, input logic [1:0] size, input logic sign,
                                            input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] v;
        int bits;
        if (wr) return 32'h0;
        if (size == 2'b10) begin
            v = (w >> (8 * addr[1:0])) & 32'hFF;
            bits = 8;
        end else if (size == 2'b01) begin
            v = (w >> (addr[1] ? 16 : 0)) & 32'hFFFF;
            bits = 16;
        end else begin
            return w;
        end
        if (sign && v[bits-1]) v = v | (32'hFFFFFFFF << bits);
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_t'(exp_q.pop_front());
            if (e.chk) begin
                check("stall",     32'(stall),              32'(e.stall));
                check("done",      32'(done),               32'(e.done));
                check("addr_err",  32'(addr_err),           32'(e.addr_err));
                check("bus_err",   32'(bus_err),            32'(e.bus_err));
                check("rdata",     rdata,                   e.rdata);
                check("bus_req",   32'(bus_if.bus_req_o),   32'(e.bus_req));
                check("bus_wr",    32'(bus_if.bus_wr_o),    32'(e.bus_wr));
                check("bus_addr",  bus_if.bus_addr_o,       e.addr);
                check("bus_be",    32'(bus_if.bus_be_o),    32'(e.be));
                check("bus_wdata", bus_if.bus_wdata_o,      e.wdata);
                if (e.idle) check("state_idle", 32'(dbg_state), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.chk = 1'b1;
        return e;
    endfunction

    task automatic push(input exp_t e);
        exp_q.push_back(EW'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic aok, input logic dok, input logic [31:0] rd);
        bus_if.bus_addr_ok_i = aok;
        bus_if.bus_data_ok_i = dok;
        bus_if.bus_rdata_i   = rd;
    endtask

    task automatic idle_cyc();
        exp_t e;
        step();
        req_valid = 1'b0;
        set_bus(1'b0, 1'($urandom_range(0, 1)), $urandom);
        e = blank();
        e.idle = 1'b1;
        push(e);
    endtask

    task automatic misaligned_cyc(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        exp_t e;
        step();
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_sign  = 1'b0;
        req_addr  = addr;
        req_wdata = $urandom;
        set_bus(1'b0, 1'($urandom_range(0, 1)), $urandom);
        e = blank();
        e.idle     = 1'b1;
        e.addr_err = 1'b1;
        push(e);
    endtask

    // a_dly: REQ cycles before addr_ok; d_dly: 0 = data with addr_ok, 1..TO = RESP cycles, >TO = never.
    // abort_at: if nonzero, rst is raised in RESP cycle abort_at+1 and the access is abandoned.
    task automatic run_txn(input logic wr, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] d,
                           input int a_dly, input int d_dly, input logic [31:0] rword,
                           input bit lit, input logic [31:0] lit_rdata, input logic [3:0] lit_be,
                           input logic [31:0] lit_wdata, input int abort_at);
        exp_t e;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        bit to;
        bit dok;
        int n;
        ebe = m_be(wr, size, addr);
        ewd = m_wdata(wr, size, d);
        erd = m_rdata(wr, size, sign, addr, rword);
        if (lit) begin
            check("model_be",    32'(ebe), 32'(lit_be));
            check("model_wdata", ewd,      lit_wdata);
            check("model_rdata", erd,      lit_rdata);
            ebe = lit_be;
            ewd = lit_wdata;
            erd = lit_rdata;
        end
        to = (d_dly > TO);

        step();
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = d;
        set_bus(1'b0, 1'($urandom_range(0, 1)), $urandom);
        e = blank();
        e.idle  = 1'b1;
        e.stall = 1'b1;
        push(e);

        for (int k = 0; k <= a_dly; k++) begin
            step();
            if (k == a_dly) set_bus(1'b1, d_dly == 0, (d_dly == 0) ? rword : $urandom);
            else            set_bus(1'b0, 1'($urandom_range(0, 1)), $urandom);
            e = blank();
            e.stall   = 1'b1;
            e.bus_req = 1'b1;
            e.bus_wr  = wr;
            e.addr    = {addr[31:2], 2'b00};
            e.be      = ebe;
            e.wdata   = ewd;
            push(e);
        end

        if (d_dly != 0) begin
            n = to ? TO : d_dly;
            for (int k = 1; k <= n; k++) begin
                step();
                if (abort_at != 0 && k == abort_at + 1) begin
                    rst       = 1'b1;
                    req_valid = 1'b0;
                    set_bus(1'b0, 1'b0, 32'h0);
                    e = blank();
                    e.chk = 1'b0;
                    push(e);
                    step();
                    rst = 1'b0;
                    set_bus(1'b0, 1'b0, 32'h0);
                    e = blank();
                    e.idle = 1'b1;
                    push(e);
                    return;
                end
                dok = !to && (k == n);
                set_bus(1'b0, dok, dok ? rword : $urandom);
                e = blank();
                e.stall = 1'b1;
                push(e);
            end
        end

        step();
        set_bus(1'b0, 1'($urandom_range(0, 1)), $urandom);
        e = blank();
        e.done    = 1'b1;
        e.rdata   = to ? 32'h0 : erd;
        e.bus_err = to;
        push(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic        wr, sign;
        logic [1:0]  size;
        logic [31:0] addr;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = '0;
        req_wdata = 32'h0;
        set_bus(1'b0, 1'b0, 32'h0);

        // reset state, including a misaligned request pending while rst is held
        for (int i = 0; i < 3; i++) begin
            step();
            rst       = 1'b1;
            req_valid = (i == 2);
            req_addr  = 32'h41;
            e = blank();
            e.idle = 1'b1;
            push(e);
        end
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        e = blank();
        e.idle = 1'b1;
        push(e);

        // LB signed 0x103, data one cycle after addr_ok
        run_txn(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0, 1, 32'h80FF1234,
                1'b1, 32'hFFFFFF80, 4'b0000, 32'h0, 0);
        idle_cyc();
        // SH 0x22, addr_ok after 3 extra cycles
        run_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD5678, 3, 1, 32'h0,
                1'b1, 32'h0, 4'b1100, 32'h56785678, 0);
        idle_cyc();
        // LW 0x41 misaligned
        misaligned_cyc(1'b0, 2'b00, 32'h41);
        idle_cyc();
        // LHU 0x2, zero-wait responder
        run_txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 0, 0, 32'h9ABC0000,
                1'b1, 32'h00009ABC, 4'b0000, 32'h0, 0);
        idle_cyc();
        // load timeout
        run_txn(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, 1, 100, 32'h0,
                1'b0, 32'h0, 4'b0, 32'h0, 0);
        idle_cyc();
        // data on the last allowed RESP cycle
        run_txn(1'b0, 2'b10, 1'b0, 32'h81, 32'h0, 0, TO, 32'h0000C300,
                1'b1, 32'h000000C3, 4'b0000, 32'h0, 0);
        // reset during RESP, then SB to 0x7
        run_txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1, 100, 32'h0,
                1'b0, 32'h0, 4'b0, 32'h0, 3);
        run_txn(1'b1, 2'b10, 1'b0, 32'h7, 32'h12345699, 0, 1, 32'h0,
                1'b1, 32'h0, 4'b1000, 32'h99999999, 0);
        idle_cyc();

        // randomized traffic, occasionally back-to-back
        for (int i = 0; i < 80; i++) begin
            wr   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sign = 1'($urandom_range(0, 1));
            addr = $urandom;
            if (m_misaligned(size, addr)) begin
                misaligned_cyc(wr, size, addr);
                idle_cyc();
            end else begin
                run_txn(wr, size, sign, addr, $urandom, $urandom_range(0, 3),
                        $urandom_range(0, TO + 2), $urandom,
                        1'b0, 32'h0, 4'b0, 32'h0, 0);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cyc();
        end

        idle_cyc();
        idle_cyc();
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_req_master.md
Name: dmem_req_master

Overview:
- MEM-stage data-memory initiator: turns one pipeline load/store into a word-aligned bus transaction with byte enables, then returns the aligned, extended load data.
- Sits between the MEM pipeline stage and the data memory/cache responder. Uses split address/data handshakes.
- Stalls the pipeline while an access is outstanding.
- Store-size encoding is shared with the responder: 2'b00 SW, 2'b01 SH, 2'b10 SB, 2'b11 treated as word.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in RESP before the access aborts with bus_err_o
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  MEM stage holds a load/store; held stable until done_o or addr_err_o
req_wr_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 word, 01 half, 10 byte, 11 word
req_sign_i  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  32  store data, LSB-justified
stall_o  output  1  freeze pipeline
done_o  output  1  one-cycle completion pulse
rdata_o  output  32  extended load data, valid while done_o=1
addr_err_o  output  1  misaligned access flag, combinational
bus_err_o  output  1  timeout abort, valid with done_o
bus_req_o  output  1  address-phase request
bus_wr_o  output  1  write request
bus_addr_o  output  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
bus_be_o  output  4  byte enables
bus_wdata_o  output  32  lane-replicated store data
bus_addr_ok_i  input  1  responder accepted address phase
bus_data_ok_i  input  1  read data valid / write acknowledged
bus_rdata_i  input  32  read word

Behaviour:
- Reset: FSM=IDLE. stall_o, done_o, bus_req_o, bus_wr_o, bus_err_o, addr_err_o = 0. bus_addr_o, bus_be_o, bus_wdata_o, rdata_o = 0. Timeout counter = 0.
- Reset mid-operation: abandons the access immediately, with no done_o. The responder is reset by the same rst.
- States: IDLE, REQ, RESP, DONE.
- Misalignment: SW with addr[1:0]!=0, or SH with addr[0]!=0.
  - In IDLE with req_valid_i=1 and misaligned: addr_err_o=1, stall_o=0, no bus activity, remain in IDLE.
- IDLE with req_valid_i=1 and aligned:
  - stall_o=1 combinationally.
  - Latch wr, size, sign, addr[1:0], be and wdata into registers.
  - Next state REQ.
- REQ:
  - bus_req_o=1 with registered addr/be/wdata/wr; these stay stable until bus_addr_ok_i.
  - addr_ok=0: stay in REQ.
  - addr_ok=1 and data_ok=0: go to RESP, clear counter.
  - addr_ok=1 and data_ok=1 in the same cycle: go to DONE, capture rdata.
  - stall_o=1.
- RESP:
  - bus_req_o=0, stall_o=1, counter increments each cycle.
  - data_ok=1: capture bus_rdata_i, go to DONE.
  - Counter reaches TIMEOUT_CYCLES: go to DONE with bus_err_o=1; rdata_o=0.
- DONE: done_o=1, stall_o=0, bus_err_o holds its latched value; next state IDLE. The pipeline advances this cycle, so no re-issue occurs.
- bus_data_ok_i is ignored in IDLE, DONE, and in REQ without addr_ok.
- Byte enables:
  - word: 1111
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100
  - byte: 0001 << addr[1:0]
- Write data:
  - word: d
  - half: {d[15:0], d[15:0]}
  - byte: {4{d[7:0]}}
- Load extraction from the captured word w:
  - half: w[15:0] when addr[1]=0, else w[31:16]
  - byte: lane addr[1:0]
  - then sign- or zero-extend to 32 bits per req_sign_i
  - stores: rdata_o=0
- Minimum latency with zero-wait responder (addr_ok and data_ok in the first REQ cycle): accept at cycle 0, REQ at cycle 1, done_o at cycle 2.
- Stall is asserted for exactly the cycles from acceptance through the last REQ/RESP cycle.

Test Plan:
- LB sign=1, addr 0x103, responder returns 0x80FF1234 one cycle after addr_ok → bus_addr_o=0x100, be=0000 (load ignores be), rdata_o=0xFFFFFF80 with done_o. Check stall_o high for 3 cycles.
- SH addr 0x22, d=0xABCD5678, addr_ok delayed 3 cycles → bus_req_o held for 4 cycles with be=1100, wdata=0x56785678, bus_wr_o=1. done_o follows data_ok by 1 cycle.
- LW addr 0x41 → addr_err_o=1, stall_o=0, bus_req_o never asserted, FSM stays in IDLE.
- LHU addr 0x2, addr_ok and data_ok in the same cycle with 0x9ABC0000 → done_o on the next cycle, rdata_o=0x00009ABC.
- Load whose data_ok never arrives, TIMEOUT_CYCLES=8 → done_o with bus_err_o=1 after 8 RESP cycles, rdata_o=0.
- rst asserted in RESP → next cycle IDLE, all outputs 0, no done_o. A new SB to 0x7 then completes normally with be=1000.
